// File: rtl/alu_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : alu_seq_pkg                                             |
// | Brief  : Opcodes, FSM state encoding and counter sizing shared   |
// |          by the sequential ALU and its iterative datapath.       |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
package alu_seq_pkg;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_add  = 4'h1;
  localparam logic [3:0] c_op_sub  = 4'h2;
  localparam logic [3:0] c_op_shlu = 4'h3;
  localparam logic [3:0] c_op_shru = 4'h4;
  localparam logic [3:0] c_op_shls = 4'h5;
  localparam logic [3:0] c_op_shrs = 4'h6;
  localparam logic [3:0] c_op_lt   = 4'h7;
  localparam logic [3:0] c_op_eq   = 4'h8;
  localparam logic [3:0] c_op_neq  = 4'h9;
  localparam logic [3:0] c_op_and  = 4'hA;
  localparam logic [3:0] c_op_or   = 4'hB;
  localparam logic [3:0] c_op_xor  = 4'hC;
  localparam logic [3:0] c_op_nor  = 4'hD;
  localparam logic [3:0] c_op_mul  = 4'hE;
  localparam logic [3:0] c_op_divu = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter must be able to represent 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : alu_seq_iter                                            |
// | Brief  : One-bit-per-cycle unsigned shift-add multiplier and,    |
// |          when ALU_SEQ_DIV_EN is defined, a restoring divider.    |
// |          o_done is high in the last of WIDTH step cycles, with   |
// |          o_res already holding the final value.                  |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_next;

  // Partial product for the current multiplier LSB; upper bits fall off (mod 2^WIDTH).
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign o_done     = r_busy && (r_cnt == c_last);

`ifdef ALU_SEQ_DIV_EN
  logic             r_is_div;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  // A zero divisor always "fits", which yields an all-ones quotient.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
  assign w_fits   = ~w_diff[WIDTH];
  assign o_res    = r_is_div ? {r_quo[WIDTH-2:0], w_fits} : w_acc_next;

  // Divider registers: dividend bits shift out as quotient bits shift in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_is_div <= 1'b0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_rem    <= '0;
    end else if (i_start) begin
      r_is_div <= i_op;
      r_quo    <= i_a;
      r_dvsr   <= i_b;
      r_rem    <= '0;
    end else if (r_busy) begin
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
      r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    end
  end
`else
  logic w_unused;
  assign w_unused = i_op;
  assign o_res    = w_acc_next;
`endif

  // Step counter and multiplier registers; one multiplier bit consumed per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : alu_seq                                                 |
// | Brief  : Sequential ALU with valid/ready handshakes. Logic,      |
// |          shift and compare ops finish in one cycle; MUL (and     |
// |          DIVU when ALU_SEQ_DIV_EN is defined) iterate WIDTH      |
// |          cycles in alu_seq_iter.                                 |
// | Rev    : 1.0 - initial release                                   |
// +------------------------------------------------------------------+
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       func_code,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             busy
);

  localparam int SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] c_width_v = WIDTH'(WIDTH);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_is_iter;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_res;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_big;
  logic [SH_W-1:0]  w_shamt;

  // The whole of B is the shift amount; anything >= WIDTH saturates.
  assign w_big   = (B >= c_width_v);
  assign w_shamt = B[SH_W-1:0];

`ifdef ALU_SEQ_DIV_EN
  assign w_is_iter = (func_code == c_op_mul) || (func_code == c_op_divu);
`else
  assign w_is_iter = (func_code == c_op_mul);
`endif

  // Single-cycle result, evaluated on the live operands in the accept cycle.
  always_comb begin
    w_alu_res = '0;
    case (func_code)
      c_op_add:  w_alu_res = A + B;
      c_op_sub:  w_alu_res = A - B;
      c_op_shlu,
      c_op_shls: w_alu_res = w_big ? '0 : (A << w_shamt);
      c_op_shru: w_alu_res = w_big ? '0 : (A >> w_shamt);
      c_op_shrs: w_alu_res = w_big ? {WIDTH{A[WIDTH-1]}}
                                   : $unsigned($signed(A) >>> w_shamt);
      c_op_lt:   w_alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      c_op_eq:   w_alu_res = {{(WIDTH-1){1'b0}}, (A == B)};
      c_op_neq:  w_alu_res = {{(WIDTH-1){1'b0}}, (A != B)};
      c_op_and:  w_alu_res = A & B;
      c_op_or:   w_alu_res = A | B;
      c_op_xor:  w_alu_res = A ^ B;
      c_op_nor:  w_alu_res = ~(A | B);
      default:   w_alu_res = '0;
    endcase
  end

  alu_seq_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_accept && w_is_iter),
    .i_op    (func_code == c_op_divu),
    .i_a     (A),
    .i_b     (B),
    .o_done  (w_iter_done),
    .o_res   (w_iter_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs; requests are only seen in IDLE.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = w_is_iter ? ST_ITER : ST_DONE;
        end
      end
      ST_ITER: begin
        busy = 1'b1;
        if (w_iter_done) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result and zero flag load once per operation and then hold through DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      result    <= '0;
      zero_flag <= 1'b1;
    end else if (w_accept && !w_is_iter) begin
      result    <= w_alu_res;
      zero_flag <= (w_alu_res == '0);
    end else if ((r_state == ST_ITER) && w_iter_done) begin
      result    <= w_iter_res;
      zero_flag <= (w_iter_res == '0);
    end
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL have port func_code  input  4  operation code.
REQ-007 SHALL have ports A and B  input  WIDTH  operands.
REQ-008 SHALL have port out_valid  output  1  result held valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  registered result.
REQ-011 SHALL have port zero_flag  output  1  registered, 1 when result is zero.
REQ-012 SHALL have port busy  output  1  high while an iterative operation is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, ITER, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request when in_valid && in_ready, capturing func_code, A and B in that cycle.
REQ-015 SHALL compute single-cycle codes 0001 ADD, 0010 SUB, 0011 SHL_U, 0100 SHR_U, 0101 SHL_S, 0110 SHR_S, 0111 LT (unsigned), 1000 EQ, 1001 NEQ, 1010 AND, 1011 OR, 1100 XOR, 1101 NOR; IDLE->DONE, out_valid the cycle after acceptance.
REQ-016 SHALL use the full B value as shift amount; B >= WIDTH gives 0 for shifts and SHL_S, and all-sign-bits for SHR_S.
REQ-017 SHALL truncate ADD/SUB/MUL results mod 2^WIDTH; LT/EQ/NEQ return 1 or 0 zero-extended.
REQ-018 SHALL implement 1110 MUL as unsigned shift-add, one bit per cycle, IDLE->ITER for exactly WIDTH cycles then DONE; out_valid WIDTH+1 cycles after acceptance; result = low WIDTH bits of A*B.
REQ-019 SHALL treat opcode 0000 and any undefined code as single-cycle with result 0 and zero_flag 1.
REQ-020 SHALL hold result, zero_flag and out_valid stable in DONE until out_ready; on out_valid && out_ready SHALL return to IDLE next cycle.
REQ-021 SHALL ignore in_valid and operand changes while in ITER or DONE.
REQ-022 SHALL assert busy exactly while in ITER.
REQ-023 SHALL compute zero_flag from the final registered result for every opcode.

Reset
REQ-024 SHALL on reset enter IDLE and drive in_ready 1, out_valid 0, busy 0, result 0, zero_flag 1, iteration counter 0.
REQ-025 SHALL abort any ITER or DONE operation when reset is asserted, discarding it without producing out_valid.

Configuration
REQ-026 SHALL use macro ALU_SEQ_DIV_EN; when defined, 1111 DIVU is an unsigned restoring divide, WIDTH ITER cycles, result = quotient.
REQ-027 SHALL, with ALU_SEQ_DIV_EN defined, return all ones for B = 0, with the same latency as a normal divide.
REQ-028 SHALL, without ALU_SEQ_DIV_EN, treat 1111 as undefined per REQ-019, with no divider logic synthesised.

Structure
REQ-029 SHALL place opcode constants, FSM state encoding and the iteration counter width ($clog2(WIDTH+1)) in package alu_seq_pkg.
REQ-030 SHALL implement MUL/DIVU datapath in sub-module alu_seq_iter (start, op, operands in; done, product/quotient out); single-cycle ops stay in alu_seq.

Verification
REQ-031 SHALL cover ADD with WIDTH=32: A=0xFFFFFFFF, B=1 -> out_valid next cycle, result 0, zero_flag 1.
REQ-032 SHALL cover MUL: A=7, B=6 -> busy for 32 cycles, out_valid at cycle 33, result 42; A=0x10000, B=0x10000 -> result 0, zero_flag 1.
REQ-033 SHALL cover SHR_S: A=0x80000000, B=40 -> result 0xFFFFFFFF; SHR_U with the same operands -> result 0.
REQ-034 SHALL cover back-pressure: out_ready low 5 cycles after SUB A=5, B=5 -> result 0 and out_valid held; a new in_valid is ignored until the handshake completes.
REQ-035 SHALL cover DIVU with ALU_SEQ_DIV_EN: A=100, B=7 -> result 14; B=0 -> 0xFFFFFFFF. Without the macro: 1111 -> result 0 after 1 cycle.
REQ-036 SHALL cover reset asserted at MUL cycle 10 -> next cycle IDLE, in_ready 1, out_valid 0, busy 0.
